lockpick_player: RTL

- Initiator-side driver for the lockpick game core.
- Holds a candidate key pair (key A, key B) loaded byte-wise by a controller.
- On `go`, performs one full attempt: start pulse, 64 input bytes, then captures and classifies the 32-byte result stream.
- Reports WIN / ERROR / LOCKED / PROTO_ERR and tracks session continuity, so retries after ERROR skip `start`.

---
 rtl/lockpick_pkg.sv | 44 ++++
 rtl/lockpick_resp_checker.sv | 58 +++++
 rtl/lockpick_player.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/lockpick_pkg.sv
// Shared types and constants for the lockpick initiator: result codes, FSM
// states, the expected result-message bytes and the game status encodings.
package lockpick_pkg;

  typedef enum logic [2:0] {
    RES_NONE   = 3'd0,
    RES_WIN    = 3'd1,
    RES_ERROR  = 3'd2,
    RES_LOCKED = 3'd3,
    RES_PROTO  = 3'd4
  } result_t;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_SEND_A    = 3'd2,
    S_SEND_B    = 3'd3,
    S_WAIT_RESP = 3'd4,
    S_RECV      = 3'd5,
    S_FINISH    = 3'd6
  } player_state_t;

  localparam logic [7:0] MSG_WIN_LO  = 8'hCE;
  localparam logic [7:0] MSG_WIN_HI  = 8'hFA;
  localparam logic [7:0] MSG_LOCK_LO = 8'hAD;
  localparam logic [7:0] MSG_LOCK_HI = 8'hDE;
  localparam logic [7:0] MSG_ERR_LO  = 8'hD0;
  localparam logic [7:0] MSG_ERR_HI  = 8'hBA;

  localparam logic [1:0] ST_ERR  = 2'b01;
  localparam logic [1:0] ST_WIN  = 2'b10;
  localparam logic [1:0] ST_LOCK = 2'b11;

  // True when the game's own status code contradicts the decoded message.
  function automatic logic status_disagrees(input result_t res, input logic [1:0] st);
    case (res)
      RES_WIN:    return st != ST_WIN;
      RES_ERROR:  return st != ST_ERR;
      RES_LOCKED: return st != ST_LOCK;
      default:    return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lockpick_resp_checker.sv
// Classifies the 32-byte game result stream by tracking, per message type,
// whether every byte so far has matched its even/odd pattern.
module lockpick_resp_checker
  import lockpick_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       byte_valid,
  input  logic [4:0] byte_idx,
  input  logic [7:0] byte_data,
  output result_t    verdict
);

  logic odd_s;
  logic win_s, lock_s, err_s;
  logic win_run_s, lock_run_s, err_run_s;
  logic win_ok_r, lock_ok_r, err_ok_r;
  logic first_s;

  assign odd_s   = byte_idx[0];
  assign first_s = (byte_idx == 5'd0);
  assign win_s   = (byte_data == (odd_s ? MSG_WIN_HI  : MSG_WIN_LO));
  assign lock_s  = (byte_data == (odd_s ? MSG_LOCK_HI : MSG_LOCK_LO));
  assign err_s   = (byte_data == (odd_s ? MSG_ERR_HI  : MSG_ERR_LO));

  // Byte 0 restarts the running flags, so no explicit clear is needed.
  assign win_run_s  = win_s  & (first_s | win_ok_r);
  assign lock_run_s = lock_s & (first_s | lock_ok_r);
  assign err_run_s  = err_s  & (first_s | err_ok_r);

  // Running "still matches" flags, advanced on every accepted byte.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      win_ok_r  <= 1'b0;
      lock_ok_r <= 1'b0;
      err_ok_r  <= 1'b0;
    end else if (byte_valid) begin
      win_ok_r  <= win_run_s;
      lock_ok_r <= lock_run_s;
      err_ok_r  <= err_run_s;
    end
  end

  // Verdict including the current byte; meaningful when byte 31 is presented.
  always_comb begin
    verdict = RES_PROTO;
    if (win_run_s) begin
      verdict = RES_WIN;
    end else if (lock_run_s) begin
      verdict = RES_LOCKED;
    end else if (err_run_s) begin
      verdict = RES_ERROR;
    end else begin
      verdict = RES_PROTO;
    end
  end

endmodule

// File: rtl/lockpick_player.sv
// Initiator for the lockpick game: streams key A then key B, captures the
// result message and reports the outcome, tracking session continuity.
module lockpick_player
  import lockpick_pkg::*;
#(
  parameter int GAP_CYCLES = 0,
  parameter int TIMEOUT    = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load_valid,
  input  logic       load_sel,
  input  logic [4:0] load_addr,
  input  logic [7:0] load_data,
  input  logic       go,
  output logic       game_start,
  output logic       game_input_enable,
  output logic [7:0] game_input_data,
  input  logic       game_output_valid,
  input  logic [7:0] game_output_data,
  input  logic [1:0] game_status,
  output logic       busy,
  output logic       done,
  output logic [2:0] result,
  output logic       status_mismatch,
  output logic       in_session
);

  localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [GW-1:0] GAP_LOAD = GW'(GAP_CYCLES);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  player_state_t state_r;
  logic [7:0]    key_a_r [32];
  logic [7:0]    key_b_r [32];
  logic [4:0]    byte_idx_r;
  logic [GW-1:0] gap_cnt_r;
  logic [TW-1:0] tmo_cnt_r;
  logic [4:0]    rx_idx_r;
  logic [1:0]    status_cap_r;

  logic [7:0]    first_a_s;
  logic [7:0]    cur_byte_s;
  logic          rx_valid_s;
  logic [4:0]    rx_idx_s;
  result_t       verdict_s;

  // Key buffers are writable only while idle and need no reset.
  always_ff @(posedge clk) begin
    if (load_valid && (state_r == S_IDLE)) begin
      if (load_sel) begin
        key_b_r[load_addr] <= load_data;
      end else begin
        key_a_r[load_addr] <= load_data;
      end
    end
  end

  // A load coinciding with go lands in the same edge, so forward it to byte 0.
  assign first_a_s  = (load_valid && !load_sel && (load_addr == 5'd0)) ? load_data : key_a_r[0];
  assign cur_byte_s = (state_r == S_SEND_B) ? key_b_r[byte_idx_r] : key_a_r[byte_idx_r];
  assign rx_valid_s = game_output_valid && ((state_r == S_WAIT_RESP) || (state_r == S_RECV));
  assign rx_idx_s   = (state_r == S_RECV) ? rx_idx_r : 5'd0;

  lockpick_resp_checker u_checker (
    .clk        (clk),
    .rst        (rst),
    .byte_valid (rx_valid_s),
    .byte_idx   (rx_idx_s),
    .byte_data  (game_output_data),
    .verdict    (verdict_s)
  );

  // Attempt sequencer with registered game-facing and status outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r           <= S_IDLE;
      game_start        <= 1'b0;
      game_input_enable <= 1'b0;
      game_input_data   <= 8'h00;
      busy              <= 1'b0;
      done              <= 1'b0;
      result            <= RES_NONE;
      status_mismatch   <= 1'b0;
      in_session        <= 1'b0;
      byte_idx_r        <= 5'd0;
      gap_cnt_r         <= '0;
      tmo_cnt_r         <= '0;
      rx_idx_r          <= 5'd0;
      status_cap_r      <= 2'b00;
    end else begin
      case (state_r)
        S_IDLE: begin
          done              <= 1'b0;
          game_start        <= 1'b0;
          game_input_enable <= 1'b0;
          game_input_data   <= 8'h00;
          if (go) begin
            busy <= 1'b1;
            if (in_session) begin
              game_input_enable <= 1'b1;
              game_input_data   <= first_a_s;
              byte_idx_r        <= 5'd1;
              gap_cnt_r         <= GAP_LOAD;
              state_r           <= S_SEND_A;
            end else begin
              game_start <= 1'b1;
              state_r    <= S_START;
            end
          end
        end
        S_START: begin
          game_start        <= 1'b0;
          game_input_enable <= 1'b1;
          game_input_data   <= key_a_r[0];
          byte_idx_r        <= 5'd1;
          gap_cnt_r         <= GAP_LOAD;
          state_r           <= S_SEND_A;
        end
        S_SEND_A, S_SEND_B: begin
          if (gap_cnt_r != '0) begin
            gap_cnt_r         <= gap_cnt_r - GW'(1);
            game_input_enable <= 1'b0;
            game_input_data   <= 8'h00;
          end else begin
            game_input_enable <= 1'b1;
            game_input_data   <= cur_byte_s;
            gap_cnt_r         <= GAP_LOAD;
            byte_idx_r        <= byte_idx_r + 5'd1;
            if (byte_idx_r == 5'd31) begin
              if (state_r == S_SEND_A) begin
                state_r <= S_SEND_B;
              end else begin
                tmo_cnt_r <= '0;
                state_r   <= S_WAIT_RESP;
              end
            end
          end
        end
        S_WAIT_RESP: begin
          game_input_enable <= 1'b0;
          game_input_data   <= 8'h00;
          if (game_output_valid) begin
            status_cap_r <= game_status;
            rx_idx_r     <= 5'd1;
            state_r      <= S_RECV;
          end else if (tmo_cnt_r == TMO_LAST) begin
            done            <= 1'b1;
            result          <= RES_PROTO;
            status_mismatch <= 1'b0;
            in_session      <= 1'b0;
            state_r         <= S_FINISH;
          end else begin
            tmo_cnt_r <= tmo_cnt_r + TW'(1);
          end
        end
        S_RECV: begin
          if (!game_output_valid) begin
            done            <= 1'b1;
            result          <= RES_PROTO;
            status_mismatch <= 1'b0;
            in_session      <= 1'b0;
            state_r         <= S_FINISH;
          end else if (rx_idx_r == 5'd31) begin
            done            <= 1'b1;
            result          <= verdict_s;
            status_mismatch <= status_disagrees(verdict_s, status_cap_r);
            in_session      <= (verdict_s == RES_ERROR);
            state_r         <= S_FINISH;
          end else begin
            rx_idx_r <= rx_idx_r + 5'd1;
          end
        end
        S_FINISH: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          state_r <= S_IDLE;
        end
        default: begin
          game_start        <= 1'b0;
          game_input_enable <= 1'b0;
          game_input_data   <= 8'h00;
          done              <= 1'b0;
          busy              <= 1'b0;
          state_r           <= S_IDLE;
        end
      endcase
    end
  end

endmodule
